// File: rtl/line_buffer_window5x5_pkg.sv
// Shared constants and window layout helper for the 5x5 line buffer and the
// convolution stage that consumes its window.
package line_buffer_window5x5_pkg;

  localparam int KSIZE     = 5;
  localparam int NUM_LINES = KSIZE - 1;

  // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c, input int dwidth);
    return (r * KSIZE + c) * dwidth;
  endfunction

endpackage

// File: rtl/line_buffer_window5x5_if.sv
// Pixel stream in / 5x5 window out bundle between the raster source, the line
// buffer and the per-channel convolver.
interface line_buffer_window5x5_if
  import line_buffer_window5x5_pkg::*;
#(
  parameter int DWIDTH = 8
) ();

  logic [DWIDTH-1:0]               data_in;
  logic                            data_valid;
  logic                            sof;
  logic [KSIZE*KSIZE*DWIDTH-1:0]   window_out;
  logic                            data_valid_out;
  logic                            frame_done;

  modport master (
    output data_in, data_valid, sof,
    input  window_out, data_valid_out, frame_done
  );

  modport slave (
    input  data_in, data_valid, sof,
    output window_out, data_valid_out, frame_done
  );

endinterface

// File: rtl/line_buffer_window5x5_line_delay.sv
// One image line of storage: write at addr on we, combinational read of the
// value stored there before this cycle's write.
module line_buffer_window5x5_line_delay #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 640
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DWIDTH-1:0]        din,
  output logic [DWIDTH-1:0]        dout
);

  logic [DWIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // NOTE: no reset on the array -- it maps onto RAM, and stale contents are never
  // exposed because the valid flag only rises once four fresh lines are written.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/line_buffer_window5x5.sv
// Raster-order pixel stream to sliding 5x5 window: four chained line memories
// feed the new window column, a col/row tracker flags in-image windows.
module line_buffer_window5x5
  import line_buffer_window5x5_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clock,
  input  logic                    reset,
  line_buffer_window5x5_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, col_eff, col_next;
  logic [RW-1:0] row, row_eff, row_next;
  logic          accept, in_window, frame_last;
  logic          win_valid, done;

  logic [NUM_LINES-1:0][DWIDTH-1:0]          line_out, line_in;
  logic [KSIZE-1:0][DWIDTH-1:0]              col_in;
  logic [KSIZE-1:0][KSIZE-1:0][DWIDTH-1:0]   win;

  assign accept = bus.data_valid;

  // sof forces this pixel to (0,0); only consulted when the pixel is accepted.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    col_eff    = bus.sof ? '0 : col;
    row_eff    = bus.sof ? '0 : row;
    in_window  = (row_eff >= RW'(KSIZE - 1)) && (col_eff >= CW'(KSIZE - 1));
    frame_last = (row_eff == RW'(IMG_HEIGHT - 1)) && (col_eff == CW'(IMG_WIDTH - 1));
    col_next   = col_eff + CW'(1);
    row_next   = row_eff;
    if (col_eff == CW'(IMG_WIDTH - 1)) begin
      col_next = '0;
      row_next = frame_last ? '0 : row_eff + RW'(1);
    end
  end

  assign line_in = {line_out[NUM_LINES-2:0], bus.data_in};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_buffer_window5x5_line_delay #(
      .DWIDTH (DWIDTH),
      .DEPTH  (IMG_WIDTH)
    ) u_line (
      .clock (clock),
      .we    (accept),
      .addr  (col_eff),
      .din   (line_in[i]),
      .dout  (line_out[i])
    );
  end

  // Newest pixel enters the bottom row; the oldest line lands in row 0.
  always_comb begin
    col_in          = '0;
    col_in[KSIZE-1] = bus.data_in;
    for (int i = 0; i < NUM_LINES; i++) col_in[NUM_LINES-1-i] = line_out[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      win_valid <= accept && in_window;
      done      <= accept && frame_last;
      if (accept) begin
        col <= col_next;
        row <= row_next;
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) win[r][c] <= win[r][c+1];
          win[r][KSIZE-1] <= col_in[r];
        end
      end
    end
  end

  always_comb begin
    bus.window_out = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        bus.window_out[win_idx(r, c, DWIDTH) +: DWIDTH] = win[r][c];
  end

  assign bus.data_valid_out = win_valid;
  assign bus.frame_done     = done;

endmodule

// File: tb/tb_line_buffer_window5x5.sv
// Self-checking bench: an image-array model predicts every window, valid and
// frame_done cycle; literal values pin the model on known pixel positions.
module tb_line_buffer_window5x5;
  import line_buffer_window5x5_pkg::*;

  localparam int DW    = 8;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int WBITS = KSIZE * KSIZE * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  line_buffer_window5x5_if #(.DWIDTH(DW)) bus ();

  line_buffer_window5x5 #(
    .DWIDTH     (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the current frame as a 2D image plus the raster position of the next pixel.
  int               img [H][W];
  int               pos_r = 0, pos_c = 0;
  logic [WBITS-1:0] nxt_win = '0, exp_win = '0;
  logic             nxt_valid = 1'b0, exp_valid = 1'b0;
  logic             nxt_fd = 1'b0, exp_fd = 1'b0;
  bit               check_en = 1'b0;

  logic [WBITS-1:0] win_q [$];
  logic [WBITS-1:0] mdl_q [$];
  logic [WBITS-1:0] ref_q [$];
  int               fd_cnt = 0;

  task automatic check(input string name, input logic [WBITS-1:0] act, input logic [WBITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int el(input logic [WBITS-1:0] w, input int r, input int c);
    return int'(w[win_idx(r, c, DW) +: DW]);
  endfunction

  // One clock cycle of stimulus; the model predicts the outputs after the next edge.
  task automatic step(input bit v, input bit s, input int d);
    @(negedge clock);
    bus.data_valid = v;
    bus.sof        = s;
    bus.data_in    = DW'(d);
    nxt_valid = 1'b0;
    nxt_fd    = 1'b0;
    nxt_win   = exp_win;
    if (v) begin
      if (s) begin
        pos_r = 0;
        pos_c = 0;
      end
      img[pos_r][pos_c] = d;
      nxt_valid = (pos_r >= KSIZE - 1) && (pos_c >= KSIZE - 1);
      nxt_fd    = (pos_r == H - 1) && (pos_c == W - 1);
      if (nxt_valid)
        for (int i = 0; i < KSIZE; i++)
          for (int j = 0; j < KSIZE; j++)
            nxt_win[(i * KSIZE + j) * DW +: DW] = DW'(img[pos_r - 4 + i][pos_c - 4 + j]);
      pos_c++;
      if (pos_c == W) begin
        pos_c = 0;
        pos_r++;
        if (pos_r == H) pos_r = 0;
      end
    end
    @(posedge clock);
    #1;
    exp_valid = nxt_valid;
    exp_fd    = nxt_fd;
    exp_win   = nxt_win;
  endtask

  // Pixel k of a frame carries value k (= row*8 + col); duty is the accept chance in percent.
  task automatic run_frame(input bit with_sof, input int duty, input int npix);
    for (int k = 0; k < npix; k++) begin
      while (int'($urandom_range(99)) >= duty)
        step(1'b0, 1'($urandom_range(1)), int'($urandom_range(255)));
      step(1'b1, with_sof && (k == 0), k);
    end
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic clear();
    win_q.delete();
    mdl_q.delete();
    fd_cnt = 0;
  endtask

  // Reset lands mid-cycle, away from any clock edge.
  task automatic do_reset();
    bus.data_valid = 1'b0;
    bus.sof        = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst valid", bus.data_valid_out, 0);
    check("async_rst frame_done", bus.frame_done, 0);
    check("async_rst window", bus.window_out, 0);
    pos_r     = 0;
    pos_c     = 0;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_win   = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_vs_ref(input string name, input int offset);
    for (int i = 0; i < ref_q.size(); i++)
      if (i + offset < win_q.size()) check(name, win_q[i + offset], ref_q[i]);
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      check("data_valid_out", bus.data_valid_out, exp_valid);
      check("frame_done", bus.frame_done, exp_fd);
      if (exp_valid) check("window_out", bus.window_out, exp_win);
      if (bus.data_valid_out) win_q.push_back(bus.window_out);
      if (exp_valid) mdl_q.push_back(exp_win);
      if (bus.frame_done) fd_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.sof        = 1'b0;
    bus.data_in    = '0;
    #2;
    check("reset valid", bus.data_valid_out, 0);
    check("reset frame_done", bus.frame_done, 0);
    check("reset window", bus.window_out, 0);
    @(negedge clock);
    reset    = 1'b0;
    check_en = 1'b1;

    // Continuous frame
    clear();
    run_frame(1'b1, 100, W * H);
    flush();
    check("f1 window count", win_q.size(), 8);
    check("f1 frame_done count", fd_cnt, 1);
    if (win_q.size() == 8 && mdl_q.size() == 8) begin
      check("f1 first (0,0)", el(win_q[0], 0, 0), 0);
      check("f1 first centre", el(win_q[0], 2, 2), 18);
      check("f1 first (4,4)", el(win_q[0], 4, 4), 36);
      check("model first centre", el(mdl_q[0], 2, 2), 18);
      check("wrap win after (4,7)", el(win_q[3], 4, 4), 39);
      check("wrap win after (5,4)", el(win_q[4], 4, 4), 44);
      check("wrap win after (5,4) (0,0)", el(win_q[4], 0, 0), 8);
      check("f1 last (4,4)", el(win_q[7], 4, 4), 47);
      check("model last (4,4)", el(mdl_q[7], 4, 4), 47);
    end
    ref_q = win_q;

    // Same frame with roughly 50% data_valid gaps
    clear();
    run_frame(1'b1, 50, W * H);
    flush();
    check("gap window count", win_q.size(), 8);
    check("gap frame_done count", fd_cnt, 1);
    check_vs_ref("gap window seq", 0);

    // Two frames back to back
    clear();
    run_frame(1'b1, 100, W * H);
    run_frame(1'b1, 100, W * H);
    flush();
    check("b2b window count", win_q.size(), 16);
    check("b2b frame_done count", fd_cnt, 2);
    check_vs_ref("b2b second frame seq", 8);

    // sof where pixel (3,2) would be
    clear();
    run_frame(1'b1, 100, 3 * W + 2);
    run_frame(1'b1, 100, W * H);
    flush();
    check("sof restart window count", win_q.size(), 8);
    check("sof restart frame_done count", fd_cnt, 1);
    if (win_q.size() > 0) check("sof restart first (4,4)", el(win_q[0], 4, 4), 36);

    // sof on what would have been the last pixel: no frame_done from the cut frame
    clear();
    run_frame(1'b1, 100, W * H - 1);
    run_frame(1'b1, 100, W * H);
    flush();
    check("sof at last window count", win_q.size(), 15);
    check("sof at last frame_done count", fd_cnt, 1);

    // Reset after pixel (4,6), then a frame without sof
    clear();
    run_frame(1'b1, 100, 4 * W + 7);
    check("valid before reset", bus.data_valid_out, 1);
    do_reset();
    clear();
    run_frame(1'b0, 100, W * H);
    flush();
    check("post-reset window count", win_q.size(), 8);
    check("post-reset frame_done count", fd_cnt, 1);
    check_vs_ref("post-reset window seq", 0);

    // Reset during the frame_done pulse
    clear();
    run_frame(1'b1, 100, W * H);
    check("frame_done before reset", bus.frame_done, 1);
    do_reset();
    clear();
    run_frame(1'b0, 100, W * H);
    flush();
    check("post-reset2 window count", win_q.size(), 8);
    check_vs_ref("post-reset2 window seq", 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_window5x5.md
Name: line_buffer_window5x5

Overview:
- Upstream stage of the per-channel 5x5 convolution.
- Accepts a raster-order stream of single-channel pixels, one per clock when data_valid is high.
- Keeps the four previous image lines in on-chip line memories and presents a full 5x5 window that a 5x5 convolution kernel consumes directly.
- One instance per colour channel; the three instances sit in front of the three per-channel convolvers.

Parameters:
- DWIDTH, 8, pixel width in bits (one colour channel).
- IMG_WIDTH, 640, pixels per line; must be at least 5.
- IMG_HEIGHT, 480, lines per frame; must be at least 5.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DWIDTH  incoming pixel.
- data_valid  in  1  data_in is accepted this cycle.
- sof  in  1  start of frame; qualified by data_valid; that pixel is row 0, col 0.
- window_out  out  25*DWIDTH  5x5 window, element (r,c) at bits [(r*5+c)*DWIDTH +: DWIDTH]. r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- data_valid_out  out  1  window_out holds a complete, in-image window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset values: col/row counters 0; all 25 window registers 0; data_valid_out 0; frame_done 0. Line memory contents are not reset; they are never exposed, see the valid rule below.
- Accept: a pixel is accepted when data_valid=1. When data_valid=0, all state holds and data_valid_out / frame_done are driven 0 the next cycle. No backpressure exists.
- Line memories: 4 arrays lb0..lb3, depth IMG_WIDTH, combinational read at address col.
  - On accept: lb0[col] <= data_in, lb1[col] <= lb0[col], lb2[col] <= lb1[col], lb3[col] <= lb2[col]. Each read returns the old value (read-before-write).
- Window shift: on accept, every row shifts left by one column, (r,c) <= (r,c+1). The new column c=4 loads row4=data_in, row3=lb0[col], row2=lb1[col], row1=lb2[col], row0=lb3[col].
- Latency: 1 cycle from the accepted pixel to the updated window_out / data_valid_out.
- Valid rule: data_valid_out=1 the cycle after a pixel accepted with row>=4 and col>=4; otherwise 0.
  - No padding: (IMG_WIDTH-4)*(IMG_HEIGHT-4) valid windows per frame.
  - The window centre is pixel (row-2, col-2).
- Counters, advanced on accept:
  - col increments and wraps from IMG_WIDTH-1 to 0; on wrap, row increments.
  - At row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both counters go to 0 and frame_done pulses the next cycle.
  - Stale columns from the previous line occupy window columns while col<4; the valid rule masks them.
- sof: when data_valid & sof, the pixel is treated as row 0, col 0 regardless of the counter values. Counters then continue from (0,1).
  - sof on a pixel that would have been the last pixel of a frame: sof wins; no frame_done pulse.
- Mid-operation reset: all outputs are driven 0 immediately (asynchronously). The next accepted pixel is (0,0). No valid window appears until (4,4) of the new frame.
- Counter widths: clog2(IMG_WIDTH) for col and clog2(IMG_HEIGHT) for row. No overflow is possible given the wrap rules.

Decomposition:
- Shared package: KSIZE=5, NUM_LINES=KSIZE-1, window bit-index helper function win_idx(r,c). The convolution stage uses the same layout.
- Sub-module line_delay: one line memory of depth IMG_WIDTH with write enable, address and combinational old-value read. Instantiated 4 times in a chain.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, DWIDTH=8; pixel value = row*8+col):
- Continuous valid, one frame -> first data_valid_out the cycle after pixel (4,4), the 37th accept. window(0,0)=0, centre=18, window(4,4)=36. Exactly 8 valid windows; last one has window(4,4)=47.
- Same frame with random data_valid gaps (about 50% duty) -> identical sequence of 8 windows. data_valid_out=0 during gap cycles.
- frame_done: exactly one pulse, the cycle after pixel (5,7) is accepted. A back-to-back second frame with sof yields 8 windows identical to the first.
- sof asserted at the pixel that would be (3,2) -> counters restart. No data_valid_out until the new (4,4); the next window has window(4,4)=36.
- Reset asserted after pixel (4,6) -> data_valid_out and frame_done drop without a clock edge; counters and window read 0. A full frame after release gives 8 correct windows.
- Line wrap: check that the windows after pixels (4,7) and (5,4) are contiguous in the stream, with no window emitted at (5,0)..(5,3).
